// File: rtl/mac_pkg.sv
// Shared defaults and FSM encoding for the MAC result divider.
package mac_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int OUT_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mac_div_step.sv
// One restoring-division step: shift in the next dividend bit, then
// subtract the divisor when the shifted partial remainder covers it.
module mac_div_step #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH:0]   part,
    input  logic                  next_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH:0]   part_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH+1:0] wide;
    logic [DATA_WIDTH:0]   diff;

    always_comb begin
        wide     = {part, next_bit};
        q_bit    = (wide >= {2'b00, divisor});
        // A successful subtract always leaves a value below the divisor,
        // so the low DATA_WIDTH+1 bits of the difference are exact.
        diff     = wide[DATA_WIDTH:0] - {1'b0, divisor};
        part_out = q_bit ? diff : wide[DATA_WIDTH:0];
    end

endmodule

// File: rtl/mac_divider.sv
// Sequential restoring divider that splits a MAC result back into a*b + c.
// Define MAC_DIVIDER_ERR_CHECK_EN to enable divide-by-zero / overflow detection.
module mac_divider
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [OUT_WIDTH-1:0]  dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  overflow,
    output logic                  div_zero
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    state_t                state_reg;
    logic [DATA_WIDTH:0]   part_reg;
    logic [DATA_WIDTH-1:0] qlow_reg;
    logic [DATA_WIDTH-1:0] dvs_reg;
    logic [CW-1:0]         cnt_reg;
    logic [DATA_WIDTH-1:0] quotient_reg;
    logic [DATA_WIDTH-1:0] remainder_reg;
    logic                  overflow_reg;
    logic                  div_zero_reg;
    logic                  done_reg;

    logic [DATA_WIDTH:0]   part_next;
    logic                  q_bit;
    logic [DATA_WIDTH-1:0] qlow_next;
    logic                  err_zero;
    logic                  err_ovf;

    mac_div_step #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_step (
        .part     (part_reg),
        .next_bit (qlow_reg[DATA_WIDTH-1]),
        .divisor  (dvs_reg),
        .part_out (part_next),
        .q_bit    (q_bit)
    );

    // Low dividend bits leave from the top while quotient bits enter at the bottom.
    assign qlow_next = {qlow_reg[DATA_WIDTH-2:0], q_bit};

    always_comb begin
`ifdef MAC_DIVIDER_ERR_CHECK_EN
        err_zero = (divisor == '0);
        err_ovf  = !err_zero && (dividend[OUT_WIDTH-1:DATA_WIDTH] >= divisor);
`else
        err_zero = 1'b0;
        err_ovf  = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            part_reg      <= '0;
            qlow_reg      <= '0;
            dvs_reg       <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            overflow_reg  <= 1'b0;
            div_zero_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done_reg <= 1'b0;
                    if (start && (err_zero || err_ovf)) begin
                        quotient_reg  <= '1;
                        remainder_reg <= '0;
                        div_zero_reg  <= err_zero;
                        overflow_reg  <= err_ovf;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else if (start) begin
                        part_reg  <= {1'b0, dividend[OUT_WIDTH-1:DATA_WIDTH]};
                        qlow_reg  <= dividend[DATA_WIDTH-1:0];
                        dvs_reg   <= divisor;
                        cnt_reg   <= '0;
                        state_reg <= CALC;
                    end
                end
                CALC: begin
                    part_reg <= part_next;
                    qlow_reg <= qlow_next;
                    cnt_reg  <= cnt_reg + CW'(1);
                    // Result ports change only once the final step is known.
                    if (cnt_reg == LAST_STEP) begin
                        quotient_reg  <= qlow_next;
                        remainder_reg <= part_next[DATA_WIDTH-1:0];
                        overflow_reg  <= 1'b0;
                        div_zero_reg  <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;
    assign overflow  = overflow_reg;
    assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_mac_divider.sv
// Self-checking bench for mac_divider: directed boundary cases plus random
// divides scored against plain integer division.
module tb_mac_divider;

    localparam int DW   = 4;
    localparam int OW   = 8;
    localparam int QMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [OW-1:0] dividend;
    logic [DW-1:0] divisor;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          overflow;
    logic          div_zero;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        int q;
        int r;
        int ovf;
        int dz;
        int lat;
    } exp_t;

    always #5 clk = ~clk;

    mac_divider #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Latency counts the start-sampling edge as edge 1.
    function automatic exp_t model(input int dd, input int dv);
        exp_t e;
        e = '0;
`ifdef MAC_DIVIDER_ERR_CHECK_EN
        if (dv == 0) begin
            e.q = QMAX; e.r = 0; e.dz = 1; e.lat = 1;
            return e;
        end
        if (dd / dv > QMAX) begin
            e.q = QMAX; e.r = 0; e.ovf = 1; e.lat = 1;
            return e;
        end
`endif
        e.q   = dd / dv;
        e.r   = dd % dv;
        e.lat = DW + 1;
        return e;
    endfunction

    task automatic do_op(input int dd, input int dv, input string tag);
        exp_t e;
        int   lat;
        bit   got;
        int   q_seen;
        e   = model(dd, dv);
        lat = 0;
        got = 0;
        @(negedge clk);
        dividend = OW'(dd);
        divisor  = DW'(dv);
        start    = 1'b1;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            start    = 1'b0;
            dividend = OW'($urandom);
            divisor  = DW'($urandom);
            lat++;
            if (done) got = 1;
        end
        $display("op %s: %0d / %0d -> q=%0d r=%0d ovf=%0d dz=%0d lat=%0d",
                 tag, dd, dv, quotient, remainder, overflow, div_zero, lat);
        check({tag, "_lat"}, lat, e.lat);
        check({tag, "_q"}, int'(quotient), e.q);
        check({tag, "_r"}, int'(remainder), e.r);
        check({tag, "_ovf"}, int'(overflow), e.ovf);
        check({tag, "_dz"}, int'(div_zero), e.dz);
        q_seen = int'(quotient);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(quotient), q_seen);
    endtask

    initial begin
        int dones;
        int dd;
        int dv;

        reset    = 1'b0;
        start    = 1'b1;
        dividend = 8'h16;
        divisor  = 4'd5;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_dz", int'(div_zero), 0);
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_start_ignored", int'(busy), 0);

        do_op(8'h16, 5, "d16_5");
        do_op(8'h43, 7, "d43_7");
        do_op(8'h7A, 9, "d7a_9");
        do_op(8'hE1, 15, "de1_15");
`ifdef MAC_DIVIDER_ERR_CHECK_EN
        do_op(8'hF0, 15, "ovf_f0_15");
        do_op(8'h16, 0, "dz_16_0");
`endif

        // Extra start pulses during CALC (cycles 2, 5) and DONE (cycle 6).
        @(negedge clk);
        dividend = 8'h43;
        divisor  = 4'd7;
        start    = 1'b1;
        dones    = 0;
        for (int c = 2; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            start    = (c == 2 || c == 5 || c == 6);
            dividend = 8'hE1;
            divisor  = 4'd15;
        end
        start = 1'b0;
        check("ignore_dones", dones, 1);
        check("ignore_q", int'(quotient), 9);
        check("ignore_r", int'(remainder), 4);
        check("ignore_idle", int'(busy), 0);

        // Reset in the third CALC cycle aborts the operation.
        @(negedge clk);
        dividend = 8'h7A;
        divisor  = 4'd9;
        start    = 1'b1;
        dones    = 0;
        for (int c = 2; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
            start = 1'b0;
            reset = (c == 4) ? 1'b0 : 1'b1;
        end
        check("abort_dones", dones, 0);
        check("abort_busy", int'(busy), 0);
        check("abort_q", int'(quotient), 0);
        check("abort_r", int'(remainder), 0);
        check("abort_ovf", int'(overflow), 0);
        check("abort_dz", int'(div_zero), 0);
        do_op(8'h7A, 9, "after_abort");

        for (int i = 0; i < 40; i++) begin
            dv = int'($urandom_range(1, QMAX));
            dd = int'($urandom_range(0, dv - 1)) * (QMAX + 1) + int'($urandom_range(0, QMAX));
`ifdef MAC_DIVIDER_ERR_CHECK_EN
            if ($urandom_range(0, 3) == 0) begin
                dv = int'($urandom_range(0, QMAX));
                dd = int'($urandom_range(0, 255));
            end
`endif
            do_op(dd, dv, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
